regfile_arbiter: RTL and testbench

- Two-requester round-robin arbiter/sequencer for the 32x16 register file (sync read, sync write, blocking write-then-read on the same posedge).
- Each requester posts one transaction: two reads plus an optional write. The arbiter drives the register-file ports, captures the read buses, and returns the data with a one-cycle done pulse.
- Sits between the register file and the datapath/test controllers that share it.

---
 rtl/regfile_arbiter.sv | 148 ++++++++++++++
 tb/tb_regfile_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// Two-requester round-robin sequencer for a 32x16 sync register file.
// Each granted transaction does two reads plus an optional write and returns the read data with a done pulse.
module regfile_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] rb0,
  input  logic [ADDR_W-1:0] rw0,
  input  logic              we0,
  input  logic [DATA_W-1:0] wd0,
  output logic              gnt0,
  output logic              done0,
  output logic [DATA_W-1:0] rda0,
  output logic [DATA_W-1:0] rdb0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] rb1,
  input  logic [ADDR_W-1:0] rw1,
  input  logic              we1,
  input  logic [DATA_W-1:0] wd1,
  output logic              gnt1,
  output logic              done1,
  output logic [DATA_W-1:0] rda1,
  output logic [DATA_W-1:0] rdb1,
  output logic [ADDR_W-1:0] rf_Ra,
  output logic [ADDR_W-1:0] rf_Rb,
  output logic [ADDR_W-1:0] rf_Rw,
  output logic              rf_WrEn,
  output logic [DATA_W-1:0] rf_busW,
  input  logic [DATA_W-1:0] rf_busA,
  input  logic [DATA_W-1:0] rf_busB,
  output logic              busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       ptr;
  logic       win;
  logic       grant_c;
  logic       pick_c;

  // Next state and winner selection; the pointer only breaks ties.
  always_comb begin
    state_nx = state;
    grant_c  = 1'b0;
    pick_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          grant_c  = 1'b1;
          pick_c   = (req0 && req1) ? ptr : req1;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE:   state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Grant, done, busy and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy  <= 1'b0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      win   <= 1'b0;
      ptr   <= 1'b0;
    end else begin
      busy  <= (state_nx != S_IDLE);
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (grant_c) begin
        win  <= pick_c;
        gnt0 <= ~pick_c;
        gnt1 <= pick_c;
      end
      if (state == S_CAPTURE) begin
        done0 <= ~win;
        done1 <= win;
      end
      if (state == S_DONE) begin
        gnt0 <= 1'b0;
        gnt1 <= 1'b0;
        ptr  <= ~win;
      end
    end
  end

  // The register-file port registers double as the latched copy of the winner's request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_Ra   <= '0;
      rf_Rb   <= '0;
      rf_Rw   <= '0;
      rf_busW <= '0;
      rf_WrEn <= 1'b0;
    end else begin
      rf_WrEn <= 1'b0;
      if (grant_c) begin
        rf_Ra   <= pick_c ? ra1 : ra0;
        rf_Rb   <= pick_c ? rb1 : rb0;
        rf_Rw   <= pick_c ? rw1 : rw0;
        rf_busW <= pick_c ? wd1 : wd0;
        rf_WrEn <= pick_c ? we1 : we0;
      end
    end
  end

  // Read buses are valid during CAPTURE; only the winner's outputs are updated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rda0 <= '0;
      rdb0 <= '0;
      rda1 <= '0;
      rdb1 <= '0;
    end else if (state == S_CAPTURE) begin
      if (win) begin
        rda1 <= rf_busA;
        rdb1 <= rf_busB;
      end else begin
        rda0 <= rf_busA;
        rdb0 <= rf_busB;
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: register-file model, transaction-level reference model,
// directed scenarios and randomized traffic.
module tb_regfile_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] ra0 = '0, rb0 = '0, rw0 = '0, ra1 = '0, rb1 = '0, rw1 = '0;
  logic we0 = 1'b0, we1 = 1'b0;
  logic [DW-1:0] wd0 = '0, wd1 = '0;
  logic gnt0, gnt1, done0, done1, rf_WrEn, busy;
  logic [DW-1:0] rda0, rdb0, rda1, rdb1, rf_busW;
  logic [DW-1:0] rf_busA, rf_busB;
  logic [AW-1:0] rf_Ra, rf_Rb, rf_Rw;
  logic mem_load = 1'b1;

  always #5 clk = ~clk;

  regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .ra0(ra0), .rb0(rb0), .rw0(rw0), .we0(we0), .wd0(wd0),
    .gnt0(gnt0), .done0(done0), .rda0(rda0), .rdb0(rdb0),
    .req1(req1), .ra1(ra1), .rb1(rb1), .rw1(rw1), .we1(we1), .wd1(wd1),
    .gnt1(gnt1), .done1(done1), .rda1(rda1), .rdb1(rdb1),
    .rf_Ra(rf_Ra), .rf_Rb(rf_Rb), .rf_Rw(rf_Rw), .rf_WrEn(rf_WrEn),
    .rf_busW(rf_busW), .rf_busA(rf_busA), .rf_busB(rf_busB), .busy(busy)
  );

  // Register file: sync write, sync read, write visible to a read on the same edge.
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'(i * 291 + 2652);
    end else begin
      if (rf_WrEn) mem[rf_Rw] <= rf_busW;
      rf_busA <= (rf_WrEn && rf_Rw == rf_Ra) ? rf_busW : mem[rf_Ra];
      rf_busB <= (rf_WrEn && rf_Rw == rf_Rb) ? rf_busW : mem[rf_Rb];
    end
  end

  // Reference model: one transaction at a time, tracked by its age in cycles since the grant edge.
  logic          m_act, m_win, m_ptr, m_we;
  int            m_age;
  logic [AW-1:0] m_ra, m_rb, m_rw;
  logic [DW-1:0] m_wd, m_pa, m_pb;
  logic [DW-1:0] m_rda [2];
  logic [DW-1:0] m_rdb [2];
  logic [DW-1:0] ref_mem [32];
  logic          pick;

  always_comb pick = (req0 && req1) ? m_ptr : req1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act <= 1'b0; m_age <= 0; m_win <= 1'b0; m_ptr <= 1'b0;
      m_ra <= '0; m_rb <= '0; m_rw <= '0; m_we <= 1'b0; m_wd <= '0;
      m_rda[0] <= '0; m_rda[1] <= '0; m_rdb[0] <= '0; m_rdb[1] <= '0;
      if (mem_load) for (int i = 0; i < 32; i++) ref_mem[i] <= 16'(i * 291 + 2652);
    end else if (m_act) begin
      if (m_age == 1) begin
        if (m_we) ref_mem[m_rw] <= m_wd;
        m_pa <= (m_we && m_rw == m_ra) ? m_wd : ref_mem[m_ra];
        m_pb <= (m_we && m_rw == m_rb) ? m_wd : ref_mem[m_rb];
      end
      if (m_age == 2) begin
        m_rda[m_win] <= m_pa;
        m_rdb[m_win] <= m_pb;
      end
      if (m_age == 3) m_act <= 1'b0;
      m_age <= m_age + 1;
    end else if (req0 || req1) begin
      m_act <= 1'b1;
      m_age <= 1;
      m_win <= pick;
      m_ptr <= ~pick;
      m_ra  <= pick ? ra1 : ra0;
      m_rb  <= pick ? rb1 : rb0;
      m_rw  <= pick ? rw1 : rw0;
      m_we  <= pick ? we1 : we0;
      m_wd  <= pick ? wd1 : wd0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("gnt0", gnt0, m_act && !m_win);
    chk("gnt1", gnt1, m_act && m_win);
    chk("busy", busy, m_act);
    chk("done0", done0, m_act && m_age == 3 && !m_win);
    chk("done1", done1, m_act && m_age == 3 && m_win);
    chk("rf_WrEn", rf_WrEn, m_act && m_age == 1 && m_we);
    chk("rf_Ra", rf_Ra, m_ra);
    chk("rf_Rb", rf_Rb, m_rb);
    chk("rf_Rw", rf_Rw, m_rw);
    chk("rf_busW", rf_busW, m_wd);
    chk("rda0", rda0, m_rda[0]);
    chk("rdb0", rdb0, m_rdb[0]);
    chk("rda1", rda1, m_rda[1]);
    chk("rdb1", rdb1, m_rdb[1]);
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_req(input int id, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] w, input logic e, input logic [DW-1:0] d);
    if (id == 0) begin
      ra0 = a; rb0 = b; rw0 = w; we0 = e; wd0 = d; req0 = 1'b1;
    end else begin
      ra1 = a; rb1 = b; rw1 = w; we1 = e; wd1 = d; req1 = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    mem_load = 1'b0;
    rst = 1'b1;
    check_all();

    // Single write + read-after-write in one transaction.
    set_req(0, 5'd3, 5'd0, 5'd3, 1'b1, 16'hBEEF);
    cycle(); req0 = 1'b0;
    chk("t1_wren_issue", rf_WrEn, 1);
    cycle();
    chk("t1_wren_capture", rf_WrEn, 0);
    cycle();
    chk("t1_done0", done0, 1);
    chk("t1_rda0", rda0, 16'hBEEF);
    chk("t1_rdb0", rdb0, 16'h0A5C);
    cycle();
    chk("t1_done0_clr", done0, 0);

    // Pointer now names requester 1, but requester 0 alone must be served at once.
    set_req(0, 5'd7, 5'd3, 5'd0, 1'b0, 16'h0);
    cycle(); req0 = 1'b0;
    chk("ptr_gnt0", gnt0, 1);
    cycle(); cycle();
    chk("ptr_rda0", rda0, 16'h1251);
    chk("ptr_rdb0", rdb0, 16'hBEEF);
    cycle();

    // Requester 1 writes reg 31, then reads it back twice.
    set_req(1, 5'd0, 5'd0, 5'd31, 1'b1, 16'h1234);
    cycle(); req1 = 1'b0;
    cycle(); cycle(); cycle();
    set_req(1, 5'd31, 5'd31, 5'd0, 1'b0, 16'h0);
    cycle(); req1 = 1'b0;
    cycle(); cycle();
    chk("t3_rda1", rda1, 16'h1234);
    chk("t3_rdb1", rdb1, 16'h1234);
    chk("t3_rda0_kept", rda0, 16'h1251);
    cycle();

    // Request fields change after grant; the latched copy is used.
    set_req(0, 5'd3, 5'd3, 5'd0, 1'b0, 16'h0);
    cycle(); req0 = 1'b0; ra0 = 5'd7;
    chk("t6_rf_Ra", rf_Ra, 5'd3);
    cycle(); cycle();
    chk("t6_rda0", rda0, 16'hBEEF);
    cycle();

    // Both requesting continuously from reset: strict alternation starting with 0.
    do_reset();
    set_req(0, 5'd1, 5'd2, 5'd4, 1'b0, 16'h0);
    set_req(1, 5'd2, 5'd1, 5'd6, 1'b0, 16'h0);
    for (int t = 0; t < 16; t++) begin
      cycle();
      if (t % 4 == 0) begin
        chk("fair_gnt0", gnt0, ((t / 4) % 2) == 0);
        chk("fair_gnt1", gnt1, ((t / 4) % 2) == 1);
      end
      if (t % 4 == 2) chk("fair_done", done0 ^ done1, 1);
    end
    req0 = 1'b0; req1 = 1'b0;
    cycle(); cycle();

    // Reset during ISSUE with a write: outputs clear at once, no done, no write.
    set_req(0, 5'd3, 5'd3, 5'd5, 1'b1, 16'hDEAD);
    cycle(); req0 = 1'b0;
    chk("rst_pre_wren", rf_WrEn, 1);
    rst = 1'b0;
    #1;
    check_all();
    chk("rst_wren", rf_WrEn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt0", gnt0, 0);
    @(negedge clk);
    check_all();
    rst = 1'b1;
    repeat (5) cycle();
    set_req(0, 5'd5, 5'd5, 5'd0, 1'b0, 16'h0);
    cycle(); req0 = 1'b0;
    cycle(); cycle();
    chk("rst_nowrite", rda0, 16'h100B);
    cycle();

    // Randomized traffic with random field churn.
    for (int n = 0; n < 1500; n++) begin
      cycle();
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      ra0 = AW'($urandom); rb0 = AW'($urandom); rw0 = AW'($urandom);
      ra1 = AW'($urandom); rb1 = AW'($urandom); rw1 = AW'($urandom);
      if ($urandom_range(0, 3) == 0) rw0 = ra0;
      if ($urandom_range(0, 3) == 0) rw1 = rb1;
      we0 = AW'($urandom_range(0, 1)) != '0;
      we1 = AW'($urandom_range(0, 1)) != '0;
      wd0 = DW'($urandom); wd1 = DW'($urandom);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (6) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
